// File: rtl/midi_voice_if.sv
// ----------------------------------------------------------------------------
// midi_voice_if
//   Bundle between the MIDI UART byte stream, the voice allocator and the
//   voice/oscillator bank.
//
//   Parameters:
//     NUM_VOICES : number of synth voices
//     VIDX_W     : voice index width, clog2(NUM_VOICES)
//
//   Signals:
//     rx_data, rx_valid   : received byte and its one-cycle strobe
//     voice_gate          : per-voice gate, 1 = sounding
//     voice_key/voice_vel : packed 7-bit key/velocity, voice i at [7i+6:7i]
//     evt_valid/evt_on    : one-cycle voice-update pulse and its on/off flag
//     evt_voice           : index of the updated voice
//     drop                : one-cycle pulse when a note-on finds no voice
//
//   Handshake: rx_valid is a bare strobe with no ready. The allocator takes
//   one byte on every cycle rx_valid is high and never stalls. evt_valid and
//   drop are single-cycle pulses with no acknowledge; the consumer must
//   sample them in the cycle they are high.
//
//   Modports: master = byte source / voice bank side, slave = allocator.
// ----------------------------------------------------------------------------
interface midi_voice_if #(
    parameter int NUM_VOICES = 4,
    parameter int VIDX_W     = 2
);
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic [NUM_VOICES-1:0]   voice_gate;
    logic [NUM_VOICES*7-1:0] voice_key;
    logic [NUM_VOICES*7-1:0] voice_vel;
    logic                    evt_valid;
    logic                    evt_on;
    logic [VIDX_W-1:0]       evt_voice;
    logic                    drop;

    modport master (
        output rx_data, rx_valid,
        input  voice_gate, voice_key, voice_vel, evt_valid, evt_on, evt_voice, drop
    );

    modport slave (
        input  rx_data, rx_valid,
        output voice_gate, voice_key, voice_vel, evt_valid, evt_on, evt_voice, drop
    );
endinterface

// File: rtl/midi_voice_allocator.sv
// ----------------------------------------------------------------------------
// midi_voice_allocator
//   Parses MIDI bytes into note-on / note-off messages (omni mode, channel
//   nibble ignored, running status supported) and assigns notes to
//   NUM_VOICES voices with LRU ranking.
//
//   Ports:
//     clk         : system clock
//     rst         : synchronous active-high reset
//     bus         : midi_voice_if.slave (byte input, voice registers, events)
//     dbg_state_o : parser state (0 = IDLE, 1 = KEY, 2 = VEL)
//
//   Optional feature macro: VOICE_STEAL_EN
//     defined   : note-on with every voice busy steals the oldest-ranked voice
//     undefined : such a note-on is discarded and drop pulses
//
//   Timing: completing byte sampled at edge T loads the message register;
//   voice registers and evt/drop update at edge T+1.
// ----------------------------------------------------------------------------
module midi_voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int VIDX_W     = 2
) (
    input  logic        clk,
    input  logic        rst,
    midi_voice_if.slave bus,
    output logic [1:0]  dbg_state_o
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEY  = 2'd1,
        ST_VEL  = 2'd2
    } state_e;

    // ---------------- parser ----------------
    state_e     state_q;
    logic       rs_valid_q;
    logic [3:0] rs_nib_q;
    logic [6:0] key_lat_q;
    logic       msg_valid_q;
    logic       msg_on_q;
    logic [6:0] msg_key_q;
    logic [6:0] msg_vel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rs_valid_q  <= 1'b0;
            rs_nib_q    <= 4'h0;
            key_lat_q   <= 7'd0;
            msg_valid_q <= 1'b0;
            msg_on_q    <= 1'b0;
            msg_key_q   <= 7'd0;
            msg_vel_q   <= 7'd0;
        end else begin
            msg_valid_q <= 1'b0;
            // Real-time bytes (0xF8-0xFF) fall through untouched.
            if (bus.rx_valid && (bus.rx_data[7:3] != 5'b11111)) begin
                if (bus.rx_data[7:4] == 4'hF) begin
                    rs_valid_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end else if (bus.rx_data[7]) begin
                    rs_nib_q   <= bus.rx_data[7:4];
                    rs_valid_q <= 1'b1;
                    state_q    <= ST_KEY;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (rs_valid_q) begin
                                key_lat_q <= bus.rx_data[6:0];
                                state_q   <= ST_VEL;
                            end
                        end
                        ST_KEY: begin
                            key_lat_q <= bus.rx_data[6:0];
                            state_q   <= ST_VEL;
                        end
                        ST_VEL: begin
                            // Non-note statuses parse the same way but are discarded here.
                            state_q     <= ST_IDLE;
                            msg_valid_q <= (rs_nib_q == 4'h8) || (rs_nib_q == 4'h9);
                            msg_on_q    <= (rs_nib_q == 4'h9) && (bus.rx_data[6:0] != 7'd0);
                            msg_key_q   <= key_lat_q;
                            msg_vel_q   <= bus.rx_data[6:0];
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign dbg_state_o = state_q;

    // ---------------- allocate stage ----------------
    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [6:0]            vkey_q [NUM_VOICES];
    logic [6:0]            vkey_d [NUM_VOICES];
    logic [6:0]            vvel_q [NUM_VOICES];
    logic [6:0]            vvel_d [NUM_VOICES];
    logic [VIDX_W-1:0]     rank_q [NUM_VOICES];
    logic [VIDX_W-1:0]     rank_d [NUM_VOICES];
    logic                  evt_valid_q, evt_valid_d;
    logic                  evt_on_q, evt_on_d;
    logic [VIDX_W-1:0]     evt_voice_q, evt_voice_d;
    logic                  drop_q, drop_d;

    logic                  hit, free_av, touch;
    logic [VIDX_W-1:0]     hit_idx, free_idx, sel_idx;
`ifdef VOICE_STEAL_EN
    localparam logic [VIDX_W-1:0] OLDEST = VIDX_W'(NUM_VOICES - 1);
    logic [VIDX_W-1:0]     old_idx;
`endif

    // Descending scan so the lowest matching index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_av  = 1'b0;
        free_idx = '0;
`ifdef VOICE_STEAL_EN
        old_idx  = '0;
`endif
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (gate_q[i] && (vkey_q[i] == msg_key_q)) begin
                hit     = 1'b1;
                hit_idx = VIDX_W'(i);
            end
            if (!gate_q[i]) begin
                free_av  = 1'b1;
                free_idx = VIDX_W'(i);
            end
`ifdef VOICE_STEAL_EN
            if (rank_q[i] == OLDEST) old_idx = VIDX_W'(i);
`endif
        end
    end

    always_comb begin
        gate_d      = gate_q;
        vkey_d      = vkey_q;
        vvel_d      = vvel_q;
        rank_d      = rank_q;
        evt_valid_d = 1'b0;
        evt_on_d    = evt_on_q;
        evt_voice_d = evt_voice_q;
        drop_d      = 1'b0;
        touch       = 1'b0;
        sel_idx     = '0;
        if (msg_valid_q) begin
            if (msg_on_q) begin
                if (hit) begin
                    touch   = 1'b1;
                    sel_idx = hit_idx;
                end else if (free_av) begin
                    touch   = 1'b1;
                    sel_idx = free_idx;
                end else begin
`ifdef VOICE_STEAL_EN
                    touch   = 1'b1;
                    sel_idx = old_idx;
`else
                    drop_d  = 1'b1;
`endif
                end
                if (touch) begin
                    gate_d[sel_idx] = 1'b1;
                    vkey_d[sel_idx] = msg_key_q;
                    vvel_d[sel_idx] = msg_vel_q;
                    evt_valid_d     = 1'b1;
                    evt_on_d        = 1'b1;
                    evt_voice_d     = sel_idx;
                    // Voices newer than the touched one age by one; touched becomes newest.
                    for (int j = 0; j < NUM_VOICES; j++) begin
                        if (VIDX_W'(j) == sel_idx) begin
                            rank_d[j] = '0;
                        end else if (rank_q[j] < rank_q[sel_idx]) begin
                            rank_d[j] = rank_q[j] + 1'b1;
                        end
                    end
                end
            end else if (hit) begin
                for (int j = 0; j < NUM_VOICES; j++) begin
                    if (gate_q[j] && (vkey_q[j] == msg_key_q)) gate_d[j] = 1'b0;
                end
                evt_valid_d = 1'b1;
                evt_on_d    = 1'b0;
                evt_voice_d = hit_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_q      <= '0;
            evt_valid_q <= 1'b0;
            evt_on_q    <= 1'b0;
            evt_voice_q <= '0;
            drop_q      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                vkey_q[i] <= 7'd0;
                vvel_q[i] <= 7'd0;
                rank_q[i] <= VIDX_W'(i);
            end
        end else begin
            gate_q      <= gate_d;
            vkey_q      <= vkey_d;
            vvel_q      <= vvel_d;
            rank_q      <= rank_d;
            evt_valid_q <= evt_valid_d;
            evt_on_q    <= evt_on_d;
            evt_voice_q <= evt_voice_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        bus.voice_key = '0;
        bus.voice_vel = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            bus.voice_key[7*i +: 7] = vkey_q[i];
            bus.voice_vel[7*i +: 7] = vvel_q[i];
        end
    end

    assign bus.voice_gate = gate_q;
    assign bus.evt_valid  = evt_valid_q;
    assign bus.evt_on     = evt_on_q;
    assign bus.evt_voice  = evt_voice_q;
    assign bus.drop       = drop_q;
endmodule
